// File: rtl/output_stream_tx.sv
// AXI-Stream result transmitter: FIFO-buffers datapath results and streams one frame of (R-K+1)*(C-K+1) beats.
// Optional TLAST generation is enabled by defining OUT_TLAST_EN; otherwise TLAST is tied low.
module output_stream_tx #(
  parameter int OUTW  = 69,
  parameter int R     = 9,
  parameter int C     = 8,
  parameter int MAXK  = 4,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [$clog2(MAXK+1)-1:0]    K,
  input  logic [OUTW-1:0]              in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [OUTW-1:0]              AXIS_TDATA,
  output logic                         AXIS_TVALID,
  input  logic                         AXIS_TREADY,
  output logic                         AXIS_TLAST,
  output logic                         frame_done
);

  localparam int PTR_BITS = $clog2(DEPTH);
  localparam int TOT_BITS = $clog2(R*C+1);
  localparam logic [PTR_BITS:0] FILL_MAX = (PTR_BITS+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t                state, state_nxt;
  logic [OUTW-1:0]       mem [DEPTH];
  logic [PTR_BITS-1:0]   wr_ptr, rd_ptr;
  logic [PTR_BITS:0]     fill;
  logic [TOT_BITS-1:0]   in_cnt, out_cnt, total, total_nxt;
  logic                  k_ok, accept_start, push, pop, is_last, last_pop, tvalid;

  // Kernel-size qualification and the frame length it implies.
  always_comb begin
    int k_int;
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    k_int     = 32'(K);
    k_ok      = (k_int >= 1) && (k_int <= MAXK) && (k_int <= R) && (k_int <= C);
    total_nxt = TOT_BITS'((R - k_int + 1) * (C - k_int + 1));
  end

  assign accept_start = (state == IDLE) && start && k_ok;
  assign in_ready     = (state == STREAM) && (fill < FILL_MAX) && (in_cnt < total);
  assign tvalid       = (state == STREAM) && (fill != '0);
  assign push         = in_valid && in_ready;
  assign pop          = tvalid && AXIS_TREADY;
  assign is_last      = (out_cnt == total - TOT_BITS'(1));
  assign last_pop     = pop && is_last;

  assign AXIS_TVALID  = tvalid;
  assign AXIS_TDATA   = mem[rd_ptr];
  assign frame_done   = (state == DONE);

`ifdef OUT_TLAST_EN
  assign AXIS_TLAST = tvalid && is_last;
`else
  assign AXIS_TLAST = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept_start) state_nxt = STREAM;
      STREAM:  if (last_pop)     state_nxt = DONE;
      DONE:                      state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      fill    <= '0;
      in_cnt  <= '0;
      out_cnt <= '0;
      total   <= '0;
    end else begin
      state <= state_nxt;
      if (accept_start) begin
        total   <= total_nxt;
        in_cnt  <= '0;
        out_cnt <= '0;
      end
      if (push) begin
        wr_ptr <= wr_ptr + PTR_BITS'(1);
        in_cnt <= in_cnt + TOT_BITS'(1);
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + PTR_BITS'(1);
        out_cnt <= out_cnt + TOT_BITS'(1);
      end
      case ({push, pop})
        2'b10:   fill <= fill + (PTR_BITS+1)'(1);
        2'b01:   fill <= fill - (PTR_BITS+1)'(1);
        default: fill <= fill;
      endcase
    end
  end

  // NOTE: storage carries no reset; occupancy is tracked by fill, so stale entries are never presented.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule
